// File: rtl/uart_rx_frame_parser_if.sv
// Signal bundle between uart_rx_frame_parser and its environment: the CoreUART
// receive/read side and the payload stream with the frame status pulses.
// master = parser side, slave = UART + downstream consumer side.
interface uart_rx_frame_parser_if;
  // CoreUART receive path
  logic       RXRDY;
  logic [7:0] UART_DATA;
  logic       PARITY_ERR;
  logic       FRAMING_ERR;
  logic       OVERFLOW;
  logic       CSN;
  logic       OEN;
  // Payload stream and frame status
  logic [7:0] PL_DATA;
  logic       PL_VALID;
  logic       PL_READY;
  logic       PL_LAST;
  logic       FRAME_OK;
  logic       FRAME_ERR;
  logic [1:0] ERR_CODE;

  modport master (
    input  RXRDY, UART_DATA, PARITY_ERR, FRAMING_ERR, OVERFLOW, PL_READY,
    output CSN, OEN, PL_DATA, PL_VALID, PL_LAST, FRAME_OK, FRAME_ERR, ERR_CODE
  );

  modport slave (
    output RXRDY, UART_DATA, PARITY_ERR, FRAMING_ERR, OVERFLOW, PL_READY,
    input  CSN, OEN, PL_DATA, PL_VALID, PL_LAST, FRAME_OK, FRAME_ERR, ERR_CODE
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Drains bytes from CoreUART through its CSN/OEN read strobe, hunts for SYNC_BYTE,
// parses a length-prefixed frame and streams the payload on a valid/ready port.
// Every frame ends with a one-cycle FRAME_OK or FRAME_ERR (+ ERR_CODE) pulse.
// Optional feature: define UART_FRAME_CHKSUM_EN to require and check a trailing
// 8-bit sum byte (LEN + payload, mod 256) after the payload.
module uart_rx_frame_parser #(
  parameter int unsigned MAX_LEN   = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'h7E,
  parameter int unsigned TIMEOUT   = 20000
) (
  input  logic                          CLK,
  input  logic                          RESET,
  uart_rx_frame_parser_if.master        bus
);

  // Read FSM encoding
  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_STROBE = 2'd1;
  localparam logic [1:0] R_GUARD1 = 2'd2;
  localparam logic [1:0] R_GUARD2 = 2'd3;

  // Frame FSM encoding
  localparam logic [1:0] F_HUNT    = 2'd0;
  localparam logic [1:0] F_LEN     = 2'd1;
  localparam logic [1:0] F_PAYLOAD = 2'd2;
`ifdef UART_FRAME_CHKSUM_EN
  localparam logic [1:0] F_CHK     = 2'd3;
`endif

  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  logic [1:0]    rd_q, rd_d;
  logic [1:0]    fr_q;
  logic [7:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    pl_data_q;
  logic          pl_valid_q;
  logic          pl_last_q;
  logic          ok_q;
  logic          err_q;
  logic [1:0]    code_q;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]    sum_q;
`endif

  logic       cap;
  logic       line_err;
  logic [7:0] rx_byte;
  logic       stalled;

  // The byte is taken at the clock edge that ends the single strobe cycle.
  assign cap      = (rd_q == R_STROBE);
  assign rx_byte  = bus.UART_DATA;
  assign line_err = bus.PARITY_ERR | bus.FRAMING_ERR | bus.OVERFLOW;
  assign stalled  = pl_valid_q & ~bus.PL_READY;

  // Read sequencer: strobe one byte, then two guard cycles for RXRDY to settle.
  always_comb begin
    rd_d = rd_q;
    case (rd_q)
      R_IDLE:   if (bus.RXRDY && !pl_valid_q) rd_d = R_STROBE;
      R_STROBE: rd_d = R_GUARD1;
      R_GUARD1: rd_d = R_GUARD2;
      default:  rd_d = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rd_q <= R_IDLE;
    else       rd_q <= rd_d;
  end

  // Frame parser, payload register, inter-byte timeout and status pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fr_q       <= F_HUNT;
      cnt_q      <= 8'd0;
      tmo_q      <= '0;
      pl_data_q  <= 8'd0;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
`ifdef UART_FRAME_CHKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      if (pl_valid_q && bus.PL_READY) begin
        pl_valid_q <= 1'b0;
        pl_last_q  <= 1'b0;
      end
      // A capture always beats a timeout landing in the same cycle.
      if (cap) begin
        tmo_q <= '0;
        case (fr_q)
          F_HUNT: begin
            if (rx_byte == SYNC_BYTE) fr_q <= F_LEN;
          end
          F_LEN: begin
            if (line_err) begin
              err_q <= 1'b1; code_q <= 2'd1; fr_q <= F_HUNT;
            end else if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
              err_q <= 1'b1; code_q <= 2'd0; fr_q <= F_HUNT;
            end else begin
              cnt_q <= rx_byte;
`ifdef UART_FRAME_CHKSUM_EN
              sum_q <= rx_byte;
`endif
              fr_q  <= F_PAYLOAD;
            end
          end
          F_PAYLOAD: begin
            if (line_err) begin
              err_q <= 1'b1; code_q <= 2'd1; fr_q <= F_HUNT;
            end else begin
              pl_data_q  <= rx_byte;
              pl_valid_q <= 1'b1;
              pl_last_q  <= (cnt_q == 8'd1);
              cnt_q      <= cnt_q - 8'd1;
`ifdef UART_FRAME_CHKSUM_EN
              sum_q      <= sum_q + rx_byte;
              if (cnt_q == 8'd1) fr_q <= F_CHK;
`else
              if (cnt_q == 8'd1) begin
                ok_q <= 1'b1;
                fr_q <= F_HUNT;
              end
`endif
            end
          end
`ifdef UART_FRAME_CHKSUM_EN
          F_CHK: begin
            if (line_err) begin
              err_q <= 1'b1; code_q <= 2'd1;
            end else if (rx_byte != sum_q) begin
              err_q <= 1'b1; code_q <= 2'd2;
            end else begin
              ok_q <= 1'b1;
            end
            fr_q <= F_HUNT;
          end
`endif
          default: fr_q <= F_HUNT;
        endcase
      end else if (fr_q != F_HUNT && !stalled) begin
        if (tmo_q == TMO_END) begin
          err_q  <= 1'b1;
          code_q <= 2'd3;
          fr_q   <= F_HUNT;
          tmo_q  <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end
    end
  end

  assign bus.CSN       = (rd_q != R_STROBE);
  assign bus.OEN       = (rd_q != R_STROBE);
  assign bus.PL_DATA   = pl_data_q;
  assign bus.PL_VALID  = pl_valid_q;
  assign bus.PL_LAST   = pl_last_q & pl_valid_q;
  assign bus.FRAME_OK  = ok_q;
  assign bus.FRAME_ERR = err_q;
  assign bus.ERR_CODE  = code_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: a byte-queue UART model feeds frames, a
// transaction-level model predicts accepted payload bytes and frame events, and
// one per-cycle compare task checks the DUT against it on the falling edge.
module tb_uart_rx_frame_parser;
  localparam int unsigned TMO  = 40;
  localparam logic [7:0]  SYNC = 8'h7E;
`ifdef UART_FRAME_CHKSUM_EN
  localparam int CHKB = 1;
`else
  localparam int CHKB = 0;
`endif

  logic CLK = 1'b0;
  logic RESET;

  uart_rx_frame_parser_if bus ();

  uart_rx_frame_parser #(
    .MAX_LEN   (64),
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TMO)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int strobes = 0;
  int last_strobe = 0;
  logic [10:0] uq[$];       // {OVERFLOW, FRAMING_ERR, PARITY_ERR, data}
  logic        pop_pend = 1'b0;
  logic [8:0]  exp_pl[$];   // {last, data}
  logic [2:0]  exp_ev[$];   // 000 = OK, {1, code} = ERR
  logic [8:0]  got_pl[$];
  logic        ready_next = 1'b1;
  logic        prev_valid = 1'b0;
  logic        prev_csn = 1'b1;
  logic [7:0]  fr [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic flag_extra(input string name, input logic [8:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h, required nothing", name, act);
  endtask

  function automatic logic [7:0] chksum(input int n);
    logic [7:0] s;
    s = n[7:0];
    for (int i = 0; i < n; i++) s = s + fr[i];
    return s;
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic [2:0] f);
    uq.push_back({f, d});
  endtask

  // Builds a well-formed frame from fr[0..n-1]; err_at selects which byte
  // (0 = LEN, 1..n = payload, n+1 = checksum) carries line-error flags ef.
  task automatic send_frame(input int n, input int err_at, input logic [2:0] ef);
    push_byte(SYNC, 3'b000);
    push_byte(n[7:0], (err_at == 0) ? ef : 3'b000);
    if (err_at == 0) begin
      exp_ev.push_back(3'b101);
      return;
    end
    for (int i = 0; i < n; i++) begin
      push_byte(fr[i], (err_at == i + 1) ? ef : 3'b000);
      if (err_at == i + 1) begin
        exp_ev.push_back(3'b101);
        return;
      end
      exp_pl.push_back({(i == n - 1), fr[i]});
    end
`ifdef UART_FRAME_CHKSUM_EN
    push_byte(chksum(n), (err_at == n + 1) ? ef : 3'b000);
    exp_ev.push_back((err_at == n + 1) ? 3'b101 : 3'b000);
`else
    exp_ev.push_back(3'b000);
`endif
  endtask

  // One clock cycle: compare on the falling edge, then update the UART model.
  task automatic tick();
    logic [8:0] e9;
    logic [2:0] ev;
    @(negedge CLK);
    cyc++;
    bus.PL_READY = ready_next;
    if (RESET) begin
      uq.delete();
      pop_pend = 1'b0;
      exp_pl.delete();
      exp_ev.delete();
      prev_valid = 1'b0;
      prev_csn = 1'b1;
    end else begin
      check("csn_eq_oen", bus.CSN, bus.OEN);
      if (bus.PL_LAST) check("last_needs_valid", bus.PL_VALID, 1);
      if (!bus.CSN) begin
        strobes++;
        last_strobe = cyc;
        check("read_gated_by_valid", prev_valid, 0);
      end
      if (bus.PL_VALID && !prev_valid) check("valid_after_capture", prev_csn, 0);
      if (bus.PL_VALID && bus.PL_READY) begin
        got_pl.push_back({bus.PL_LAST, bus.PL_DATA});
        if (exp_pl.size() == 0) flag_extra("payload_extra", {bus.PL_LAST, bus.PL_DATA});
        else begin
          e9 = exp_pl.pop_front();
          check("pl_data", bus.PL_DATA, e9[7:0]);
          check("pl_last", bus.PL_LAST, e9[8]);
        end
      end
      if (bus.FRAME_OK || bus.FRAME_ERR) begin
        check("ok_err_exclusive", bus.FRAME_OK && bus.FRAME_ERR, 0);
        ev = bus.FRAME_ERR ? {1'b1, bus.ERR_CODE} : 3'b000;
        if (exp_ev.size() == 0) flag_extra("event_extra", {6'd0, ev});
        else check("event", ev, exp_ev.pop_front());
        if (ev == 3'b111) check("timeout_distance", cyc - last_strobe, TMO + 1);
        else check("pulse_after_capture", prev_csn, 0);
`ifndef UART_FRAME_CHKSUM_EN
        if (bus.FRAME_OK) check("ok_with_last_rise", bus.PL_VALID && bus.PL_LAST && !prev_valid, 1);
`endif
      end
      prev_valid = bus.PL_VALID;
      prev_csn = bus.CSN;
    end
    if (pop_pend) begin
      void'(uq.pop_front());
      pop_pend = 1'b0;
    end
    if (!RESET && !bus.CSN && !bus.OEN && uq.size() != 0) pop_pend = 1'b1;
    if (uq.size() != 0) {bus.OVERFLOW, bus.FRAMING_ERR, bus.PARITY_ERR, bus.UART_DATA} = uq[0];
    else {bus.OVERFLOW, bus.FRAMING_ERR, bus.PARITY_ERR, bus.UART_DATA} = 11'd0;
    bus.RXRDY = (uq.size() != 0) && !pop_pend;
  endtask

  task automatic drain();
    int k = 0;
    while ((uq.size() != 0 || pop_pend || bus.PL_VALID || exp_ev.size() != 0) && k < 2000) begin
      tick();
      k++;
    end
    repeat (6) tick();
    check("drain_events", exp_ev.size(), 0);
    check("drain_payload", exp_pl.size(), 0);
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!bus.PL_VALID && k < max) begin
      tick();
      k++;
    end
    check("wait_valid", bus.PL_VALID, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csn"}, bus.CSN, 1);
    check({tag, "_oen"}, bus.OEN, 1);
    check({tag, "_pl_data"}, bus.PL_DATA, 0);
    check({tag, "_pl_valid"}, bus.PL_VALID, 0);
    check({tag, "_pl_last"}, bus.PL_LAST, 0);
    check({tag, "_frame_ok"}, bus.FRAME_OK, 0);
    check({tag, "_frame_err"}, bus.FRAME_ERR, 0);
    check({tag, "_err_code"}, bus.ERR_CODE, 0);
  endtask

  initial begin
    int base;
    int s0;
    RESET = 1'b1;
    bus.RXRDY = 1'b0;
    bus.UART_DATA = 8'd0;
    bus.PARITY_ERR = 1'b0;
    bus.FRAMING_ERR = 1'b0;
    bus.OVERFLOW = 1'b0;
    bus.PL_READY = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    RESET = 1'b0;
    repeat (2) tick();

    // Frame 7E 03 11 22 33 [69]
    fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33;
    check("model_chksum_3", chksum(3), 8'h69);
    base = got_pl.size();
    send_frame(3, -1, 3'b000);
    drain();
    check("t1_count", got_pl.size() - base, 3);
    check("t1_b0", got_pl[base], 9'h011);
    check("t1_b1", got_pl[base + 1], 9'h022);
    check("t1_b2", got_pl[base + 2], 9'h133);

    // Leading garbage 00 55, then 7E 01 AA [AB]
    fr[0] = 8'hAA;
    check("model_chksum_1", chksum(1), 8'hAB);
    base = got_pl.size();
    s0 = strobes;
    push_byte(8'h00, 3'b000);
    push_byte(8'h55, 3'b000);
    send_frame(1, -1, 3'b000);
    drain();
    check("t2_strobes", strobes - s0, 5 + CHKB);
    check("t2_count", got_pl.size() - base, 1);
    check("t2_b0", got_pl[base], 9'h1AA);

    // Length 00, length 41 (> 64), LEN with overflow, then a good frame
    base = got_pl.size();
    push_byte(SYNC, 3'b000); push_byte(8'h00, 3'b000); exp_ev.push_back(3'b100);
    push_byte(SYNC, 3'b000); push_byte(8'h41, 3'b000); exp_ev.push_back(3'b100);
    fr[0] = 8'h5A; fr[1] = 8'hA5;
    send_frame(2, 0, 3'b100);
    send_frame(2, -1, 3'b000);
    drain();
    check("t3_count", got_pl.size() - base, 2);
    check("t3_last", got_pl[base + 1], 9'h1A5);

    // Parity error on the second payload byte
    base = got_pl.size();
    fr[0] = 8'h10; fr[1] = 8'h20; fr[2] = 8'h30;
    send_frame(3, 2, 3'b001);
    drain();
    check("t4_count", got_pl.size() - base, 1);
    check("t4_b0", got_pl[base], 9'h010);

`ifdef UART_FRAME_CHKSUM_EN
    // Framing error on the checksum byte, then a wrong checksum byte
    send_frame(3, 4, 3'b010);
    push_byte(SYNC, 3'b000); push_byte(8'h01, 3'b000); push_byte(8'h40, 3'b000);
    push_byte(8'h42, 3'b000);
    exp_pl.push_back(9'h140);
    exp_ev.push_back(3'b110);
    drain();
`endif

    // Long backpressure mid-payload: no reads, no timeout
    ready_next = 1'b0;
    fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33;
    s0 = strobes;
    send_frame(3, -1, 3'b000);
    wait_valid(200);
    repeat (1000) tick();
    check("stall_strobes", strobes - s0, 3);
    check("stall_valid", bus.PL_VALID, 1);
    check("stall_data", bus.PL_DATA, 8'h11);
    ready_next = 1'b1;
    drain();

    // Input stops mid-payload: timeout abort
    s0 = strobes;
    push_byte(SYNC, 3'b000); push_byte(8'h03, 3'b000);
    push_byte(8'h11, 3'b000); push_byte(8'h22, 3'b000);
    exp_pl.push_back(9'h011);
    exp_pl.push_back(9'h022);
    exp_ev.push_back(3'b111);
    drain();
    check("tmo_strobes", strobes - s0, 4);

    // Reset while a payload byte is held
    ready_next = 1'b0;
    push_byte(SYNC, 3'b000); push_byte(8'h03, 3'b000);
    push_byte(8'h11, 3'b000); push_byte(8'h22, 3'b000); push_byte(8'h33, 3'b000);
    wait_valid(200);
    check("pre_rst_data", bus.PL_DATA, 8'h11);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("midrst");
    ready_next = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    repeat (2) tick();
    base = got_pl.size();
    fr[0] = 8'h77;
    send_frame(1, -1, 3'b000);
    drain();
    check("post_rst_count", got_pl.size() - base, 1);
    check("post_rst_b0", got_pl[base], 9'h177);

    check("final_queues", exp_ev.size() + exp_pl.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
